// File: rtl/pc_pkg.sv
// pc_pkg -- definitions shared by the PC sequencer and its return stack.
//   PC_ADDR_W       default PC width in bits
//   PC_STEP         sequential increment in bytes
//   PC_RESET_VECTOR PC after reset
//   PC_EXC_VECTOR   PC after an exception redirect
//   PC_RAS_DEPTH    default return-address-stack depth
//   pc_src_e        next-PC source selected by the priority mux
package pc_pkg;

  localparam int          PC_ADDR_W       = 32;
  localparam int          PC_STEP         = 4;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0080;
  localparam int          PC_RAS_DEPTH    = 4;

  typedef enum logic [2:0] {
    SRC_HOLD   = 3'd0,  // stalled: PC and stack untouched
    SRC_EXC    = 3'd1,
    SRC_BRANCH = 3'd2,
    SRC_CALL   = 3'd3,
    SRC_JUMP   = 3'd4,
    SRC_RET    = 3'd5,
    SRC_SEQ    = 3'd6
  } pc_src_e;

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack -- circular return-address stack.
//   clock, reset : clock and synchronous active-high reset (clears count only)
//   push         : write pushData on top; when full the oldest entry is lost
//   pop          : drop the top entry (ignored when empty)
//   pushData     : address to push
//   top          : current top entry, combinational read
//   count        : number of valid entries, 0..DEPTH
//   empty, full  : count == 0, count == DEPTH
module pc_return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           pushData,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] entry_reg [DEPTH];
  // wr_ptr_reg points at the slot the next push writes; top lives one below.
  // Because the pointer wraps, pushing when full overwrites the oldest entry.
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic do_push;
  logic do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_push = push;
  assign do_pop  = pop && !push && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (do_push) begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (!full)
        count_reg <= count_reg + CNT_W'(1);
    end else if (do_pop) begin
      wr_ptr_reg <= wr_ptr_reg - PTR_W'(1);
      count_reg  <= count_reg - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clock) begin
    if (!reset && do_push)
      entry_reg[wr_ptr_reg] <= pushData;
  end

  assign top   = entry_reg[wr_ptr_reg - PTR_W'(1)];
  assign count = count_reg;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with exception/branch/call/jump/return
// redirects and a circular return-address stack.
//   clock, reset      : clock, synchronous active-high reset
//   pcWrite           : advance enable (excReq still redirects when 0)
//   excReq            : load EXC_VECTOR
//   branchTaken       : load branchTarget
//   call              : load jumpTarget and push pcPlusStep
//   jump              : load jumpTarget
//   ret               : pop the stack and load the popped address
//   branchTarget, jumpTarget : redirect destinations
//   pcOutput          : registered PC
//   pcPlusStep        : pcOutput + STEP, wraps modulo 2^ADDR_W
//   rasEmpty, rasFull : stack occupancy flags
//   rasUnderflow      : one-cycle pulse after a ret on an empty stack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = PC_ADDR_W,
  parameter int                STEP         = PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(PC_EXC_VECTOR),
  parameter int                RAS_DEPTH    = PC_RAS_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pcWrite,
  input  logic              excReq,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic              jump,
  input  logic              call,
  input  logic [ADDR_W-1:0] jumpTarget,
  input  logic              ret,
  output logic [ADDR_W-1:0] pcOutput,
  output logic [ADDR_W-1:0] pcPlusStep,
  output logic              rasEmpty,
  output logic              rasFull,
  output logic              rasUnderflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              underflow_reg;
  logic              underflow_next;
  pc_src_e           src_sel;

  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_push;
  logic              ras_pop;

  assign pcPlusStep = pc_reg + ADDR_W'(STEP);

  // Priority select: excReq overrides the stall; everything else needs pcWrite.
  always_comb begin
    src_sel = SRC_HOLD;
    if (excReq)           src_sel = SRC_EXC;
    else if (pcWrite) begin
      if (branchTaken)    src_sel = SRC_BRANCH;
      else if (call)      src_sel = SRC_CALL;
      else if (jump)      src_sel = SRC_JUMP;
      else if (ret)       src_sel = SRC_RET;
      else                src_sel = SRC_SEQ;
    end
  end

  always_comb begin
    pc_next        = pc_reg;
    underflow_next = 1'b0;
    case (src_sel)
      SRC_EXC:    pc_next = EXC_VECTOR;
      SRC_BRANCH: pc_next = branchTarget;
      SRC_CALL:   pc_next = jumpTarget;
      SRC_JUMP:   pc_next = jumpTarget;
      SRC_RET: begin
        // An empty stack degrades ret into a sequential step and flags it.
        if (ras_empty) begin
          pc_next        = pcPlusStep;
          underflow_next = 1'b1;
        end else begin
          pc_next = ras_top;
        end
      end
      SRC_SEQ:    pc_next = pcPlusStep;
      default:    pc_next = pc_reg;
    endcase
  end

  assign ras_push = (src_sel == SRC_CALL);
  assign ras_pop  = (src_sel == SRC_RET) && !ras_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg        <= RESET_VECTOR;
      underflow_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      underflow_reg <= underflow_next;
    end
  end

  pc_return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock    (clock),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .pushData (pcPlusStep),
    .top      (ras_top),
    .count    (ras_count),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign pcOutput     = pc_reg;
  assign rasEmpty     = (ras_count == '0);
  assign rasFull      = ras_full;
  assign rasUnderflow = underflow_reg;

endmodule
